// File: rtl/lcd_sequencer.sv
// lcd_sequencer
// Drives a character LCD controller: runs the power-on initialisation
// sequence, then forwards host bytes one at a time with the
// controller's setup/enable/hold timing and post-command delays.
//
// Ports
//    Clock      system clock, all logic on its rising edge
//    Reset      synchronous, active-low
//    Modo_OP    [1] two-line mode, [0] increment entry; captured once after reset
//    in_valid   host offers a byte
//    in_rs      register select of the offered byte (0 command, 1 data)
//    in_data    offered byte
//    in_ready   byte accepted on in_valid & in_ready
//    LCD_EN     enable strobe
//    LCD_RS     register select
//    LCD_RW     read/write select, always write
//    LCD_DADOS  data bus; in 4-bit mode only [7:4] carries data
//    idle       initialisation done and no transfer in progress
module lcd_sequencer #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BUS_WIDTH   = 8,
   parameter int EN_CYCLES   = 25,
   parameter int POWERUP_US  = 40000,
   parameter int CMD_US      = 50,
   parameter int CLEAR_US    = 2000,
   parameter int WAKE1_US    = 4100
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [1:0] Modo_OP,
   input  logic       in_valid,
   input  logic       in_rs,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       LCD_EN,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [7:0] LCD_DADOS,
   output logic       idle
);

   localparam int   TICK_DIV = (CLK_FREQ_HZ / 1_000_000 < 1) ? 1 : CLK_FREQ_HZ / 1_000_000;
   localparam int   PRESC_W  = $clog2(TICK_DIV + 1);
   localparam int   EN_W     = $clog2(EN_CYCLES + 1);
   localparam logic FOUR_BIT = 1'(BUS_WIDTH == 4);

   typedef enum logic [3:0] {
      S_POWERUP, S_WAKE1, S_WAKE2, S_WAKE3, S_FUNC4, S_FUNC,
      S_DISP_OFF, S_CLEAR, S_ENTRY, S_DISP_ON, S_READY, S_XFER
   } state_t;

   typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT} phase_t;

   state_t             state, state_nx;
   phase_t             phase, phase_nx;
   logic               low_nib, low_nib_nx;
   logic [EN_W-1:0]    en_cnt, en_cnt_nx;
   logic [31:0]        wait_cnt, wait_cnt_nx;
   logic [PRESC_W-1:0] presc;
   logic               tick;
   logic               xfer_rs, xfer_rs_nx;
   logic [7:0]         xfer_data, xfer_data_nx;
   logic [1:0]         modo;
   logic               modo_loaded;

   logic [7:0]  step_byte;
   logic        step_rs;
   logic [31:0] step_wait;
   logic        step_single;
   logic        last_strobe;
   logic [31:0] cur_wait;
   logic [7:0]  bus_value;
   logic        step_done;

   assign tick = (presc == PRESC_W'(TICK_DIV - 1));

   // Registers: FSM state, strobe phase, counters, prescaler and the
   // captured host byte. Modo_OP is taken once, on the first edge after
   // reset is released, and ignored from then on.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state       <= S_POWERUP;
         phase       <= PH_WAIT;
         low_nib     <= 1'b0;
         en_cnt      <= '0;
         wait_cnt    <= '0;
         presc       <= '0;
         xfer_rs     <= 1'b0;
         xfer_data   <= 8'h00;
         modo        <= 2'b00;
         modo_loaded <= 1'b0;
      end else begin
         state     <= state_nx;
         phase     <= phase_nx;
         low_nib   <= low_nib_nx;
         en_cnt    <= en_cnt_nx;
         wait_cnt  <= wait_cnt_nx;
         presc     <= tick ? '0 : presc + PRESC_W'(1);
         xfer_rs   <= xfer_rs_nx;
         xfer_data <= xfer_data_nx;
         if (!modo_loaded) begin
            modo        <= Modo_OP;
            modo_loaded <= 1'b1;
         end
      end
   end

   // Step decode: what byte the current state sends, with which RS,
   // how long to wait afterwards, and whether it is a lone upper-nibble
   // strobe (wake-up and 4-bit switch commands).
   always_comb begin
      step_byte   = 8'h00;
      step_rs     = 1'b0;
      step_wait   = 32'(CMD_US);
      step_single = 1'b0;
      case (state)
         S_POWERUP: begin
            step_wait   = 32'(POWERUP_US);
            step_single = 1'b1;
         end
         S_WAKE1: begin
            step_byte   = 8'h30;
            step_wait   = 32'(WAKE1_US);
            step_single = 1'b1;
         end
         S_WAKE2: begin
            step_byte   = 8'h30;
            step_wait   = 32'd100;
            step_single = 1'b1;
         end
         S_WAKE3: begin
            step_byte   = 8'h30;
            step_single = 1'b1;
         end
         S_FUNC4: begin
            step_byte   = 8'h20;
            step_single = 1'b1;
         end
         S_FUNC:     step_byte = {3'b001, ~FOUR_BIT, modo[1], 3'b000};
         S_DISP_OFF: step_byte = 8'h08;
         S_CLEAR: begin
            step_byte = 8'h01;
            step_wait = 32'(CLEAR_US);
         end
         S_ENTRY:    step_byte = {6'b000001, modo[0], 1'b0};
         S_DISP_ON:  step_byte = 8'h0C;
         S_XFER: begin
            step_byte = xfer_data;
            step_rs   = xfer_rs;
            if (!xfer_rs && (xfer_data == 8'h01 || xfer_data == 8'h02 || xfer_data == 8'h03))
               step_wait = 32'(CLEAR_US);
         end
         default: ;
      endcase
   end

   // In 4-bit mode a full byte is two strobes; the 1 us gap follows the
   // high nibble and the step's own delay follows the low nibble only.
   assign last_strobe = step_single | ~FOUR_BIT | low_nib;
   assign cur_wait    = last_strobe ? step_wait : 32'd1;
   assign bus_value   = (!FOUR_BIT && !step_single) ? step_byte :
                        (low_nib ? {step_byte[3:0], 4'h0} : {step_byte[7:4], 4'h0});

   // Next-state logic: READY waits for a host byte, every other state
   // walks SETUP -> PULSE -> HOLD -> WAIT for each strobe, then advances
   // to the following init step (or back to READY after a transfer).
   always_comb begin
      state_nx     = state;
      phase_nx     = phase;
      low_nib_nx   = low_nib;
      en_cnt_nx    = en_cnt;
      wait_cnt_nx  = wait_cnt;
      xfer_rs_nx   = xfer_rs;
      xfer_data_nx = xfer_data;
      step_done    = 1'b0;
      if (state == S_READY) begin
         if (in_valid) begin
            xfer_rs_nx   = in_rs;
            xfer_data_nx = in_data;
            state_nx     = S_XFER;
            phase_nx     = PH_SETUP;
            low_nib_nx   = 1'b0;
         end
      end else begin
         case (phase)
            PH_SETUP: begin
               phase_nx  = PH_PULSE;
               en_cnt_nx = '0;
            end
            PH_PULSE: begin
               if (en_cnt == EN_W'(EN_CYCLES - 1))
                  phase_nx = PH_HOLD;
               else
                  en_cnt_nx = en_cnt + EN_W'(1);
            end
            PH_HOLD: begin
               phase_nx    = PH_WAIT;
               wait_cnt_nx = '0;
            end
            PH_WAIT: begin
               if (tick) begin
                  if (wait_cnt + 32'd1 >= cur_wait) begin
                     if (last_strobe) begin
                        step_done = 1'b1;
                     end else begin
                        low_nib_nx = 1'b1;
                        phase_nx   = PH_SETUP;
                     end
                  end else begin
                     wait_cnt_nx = wait_cnt + 32'd1;
                  end
               end
            end
         endcase
      end
      if (step_done) begin
         low_nib_nx  = 1'b0;
         phase_nx    = PH_SETUP;
         wait_cnt_nx = '0;
         en_cnt_nx   = '0;
         case (state)
            S_POWERUP:  state_nx = S_WAKE1;
            S_WAKE1:    state_nx = S_WAKE2;
            S_WAKE2:    state_nx = S_WAKE3;
            S_WAKE3:    state_nx = FOUR_BIT ? S_FUNC4 : S_FUNC;
            S_FUNC4:    state_nx = S_FUNC;
            S_FUNC:     state_nx = S_DISP_OFF;
            S_DISP_OFF: state_nx = S_CLEAR;
            S_CLEAR:    state_nx = S_ENTRY;
            S_ENTRY:    state_nx = S_DISP_ON;
            default:    state_nx = S_READY;
         endcase
      end
   end

   // Outputs: bus and RS are driven for the whole step so they are
   // stable from SETUP through HOLD; POWERUP and READY keep the bus at 0.
   always_comb begin
      LCD_RW    = 1'b0;
      in_ready  = (state == S_READY);
      idle      = (state == S_READY);
      LCD_EN    = 1'b0;
      LCD_RS    = 1'b0;
      LCD_DADOS = 8'h00;
      if (state != S_POWERUP && state != S_READY) begin
         LCD_EN    = (phase == PH_PULSE);
         LCD_RS    = step_rs;
         LCD_DADOS = bus_value;
      end
   end

endmodule
